conv_row_window: RTL and testbench

Sliding-window generator that sits directly downstream of channel_buffer in every conv layer. It consumes a raster-order stream of pixels, where each beat carries all NUM_CHANNEL channels of one pixel. It emits KERNEL_SIZE horizontally adjacent pixels as one wide window, honouring STRIDE and never mixing rows. Input and output both use the valid/rdy handshake; the output is registered.

---
 rtl/conv_row_window_pkg.sv | 7 +
 rtl/window_shift_reg.sv | 21 ++
 rtl/conv_row_window.sv | 67 ++++++
 tb/tb_conv_row_window.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_row_window_pkg.sv
// conv_row_window_pkg: shared handshake state encodings and counter sizing helper
package conv_row_window_pkg;
  typedef enum logic {TX_IDLE = 1'b0, TX_WAIT_FOR_RDY = 1'b1} tx_state_t;
  function automatic int clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/window_shift_reg.sv
// window_shift_reg: K-slot pixel shift register; window shows the contents as they will be after a shift of din
module window_shift_reg #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              shift_en,
  input  logic [DATA_WIDTH-1:0]             din,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] window
);
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] q;
  if (KERNEL_SIZE == 1) begin : g_one
    assign window = din;
  end else begin : g_many
    assign window = {din, q[KERNEL_SIZE*DATA_WIDTH-1:DATA_WIDTH]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (shift_en) q <= window;
endmodule

// File: rtl/conv_row_window.sv
// conv_row_window: raster pixel stream to strided horizontal K-pixel windows with registered valid/rdy output
module conv_row_window import conv_row_window_pkg::*; #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_WIDTH = 8,
  parameter int STRIDE = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      prev_layer_valid,
  output logic                                      prev_layer_rdy,
  input  logic [NUM_CHANNEL*BIT_WIDTH-1:0]          prev_layer_data,
  input  logic                                      next_layer_rdy,
  output logic                                      next_layer_valid,
  output logic [KERNEL_SIZE*NUM_CHANNEL*BIT_WIDTH-1:0] next_layer_data,
  output logic                                      next_layer_last
);
  localparam int P = NUM_CHANNEL * BIT_WIDTH;
  localparam int CW = clog2(IMAGE_WIDTH);
  localparam int SW = clog2(STRIDE);
  localparam int LAST_COL = KERNEL_SIZE - 1 + ((IMAGE_WIDTH - KERNEL_SIZE) / STRIDE) * STRIDE;
  if (KERNEL_SIZE < 1 || KERNEL_SIZE > IMAGE_WIDTH || STRIDE < 1) begin : g_bad_params
    $error("conv_row_window: need 1 <= KERNEL_SIZE <= IMAGE_WIDTH and STRIDE >= 1");
  end
  tx_state_t state;
  logic [CW-1:0] col;
  logic [SW-1:0] sc, sc_cur;
  logic accept, emit;
  logic [KERNEL_SIZE*P-1:0] window;
  assign prev_layer_rdy = !rst && (state == TX_IDLE || next_layer_rdy);
  assign accept = prev_layer_valid && prev_layer_rdy;
  // stride phase restarts at the first full window of each row
  assign sc_cur = (col == CW'(KERNEL_SIZE - 1)) ? '0 : sc;
  assign emit = col >= CW'(KERNEL_SIZE - 1) && sc_cur == '0;
  window_shift_reg #(.KERNEL_SIZE(KERNEL_SIZE), .DATA_WIDTH(P)) u_shift (
    .clk(clk),
    .rst(rst),
    .shift_en(accept),
    .din(prev_layer_data),
    .window(window)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= TX_IDLE;
      col <= '0;
      sc <= '0;
      next_layer_valid <= 1'b0;
      next_layer_last <= 1'b0;
      next_layer_data <= '0;
    end else begin
      if (accept) begin
        col <= (col == CW'(IMAGE_WIDTH - 1)) ? '0 : col + 1'b1;
        sc <= (sc_cur == SW'(STRIDE - 1)) ? '0 : sc_cur + 1'b1;
      end
      if (accept && emit) begin
        state <= TX_WAIT_FOR_RDY;
        next_layer_valid <= 1'b1;
        next_layer_data <= window;
        next_layer_last <= col == CW'(LAST_COL);
      end else if (next_layer_rdy) begin
        state <= TX_IDLE;
        next_layer_valid <= 1'b0;
        next_layer_last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_conv_row_window.sv
// tb_conv_row_window: vector table, corner sequences and randomized model checks for conv_row_window
module tb_conv_row_window;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, rdy = 1'b0;
  logic [23:0] din = '0;
  logic a_rdy, a_v, a_l, b_rdy, b_v, b_l, c_rdy, c_v, c_l;
  logic [23:0] a_d, b_d;
  logic [95:0] c_d;
  int tests = 0, fails = 0;
  typedef struct {
    logic v; logic r; logic [7:0] d;
    logic ev; logic [23:0] ed; logic el; logic erdy;
  } vec_t;
  typedef struct { logic [23:0] d; logic l; } win_t;
  vec_t tbl[23];
  win_t exp_q[$];
  logic [23:0] hist[3][8];
  int mcol[3];
  always #5 clk = ~clk;

  conv_row_window #(.BIT_WIDTH(8), .NUM_CHANNEL(1), .KERNEL_SIZE(3), .IMAGE_WIDTH(8), .STRIDE(1)) u_a (
    .clk(clk), .rst(rst), .prev_layer_valid(valid), .prev_layer_rdy(a_rdy), .prev_layer_data(din[7:0]),
    .next_layer_rdy(rdy), .next_layer_valid(a_v), .next_layer_data(a_d), .next_layer_last(a_l));
  conv_row_window #(.BIT_WIDTH(8), .NUM_CHANNEL(1), .KERNEL_SIZE(3), .IMAGE_WIDTH(8), .STRIDE(2)) u_b (
    .clk(clk), .rst(rst), .prev_layer_valid(valid), .prev_layer_rdy(b_rdy), .prev_layer_data(din[7:0]),
    .next_layer_rdy(rdy), .next_layer_valid(b_v), .next_layer_data(b_d), .next_layer_last(b_l));
  conv_row_window #(.BIT_WIDTH(8), .NUM_CHANNEL(3), .KERNEL_SIZE(4), .IMAGE_WIDTH(4), .STRIDE(1)) u_c (
    .clk(clk), .rst(rst), .prev_layer_valid(valid), .prev_layer_rdy(c_rdy), .prev_layer_data(din),
    .next_layer_rdy(rdy), .next_layer_valid(c_v), .next_layer_data(c_d), .next_layer_last(c_l));

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; rdy = 1'b0; din = '0;
    #2;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) mcol[i] = 0;
  endtask

  function automatic vec_t mk(input logic v, r, input logic [7:0] d, input logic ev,
                              input logic [23:0] ed, input logic el, erdy);
    mk.v = v; mk.r = r; mk.d = d; mk.ev = ev; mk.ed = ed; mk.el = el; mk.erdy = erdy;
  endfunction

  // row model: emit when (col-(k-1)) is a non-negative multiple of s, last when the next stride leaves the row
  task automatic model(input int id, k, s, w, nc, input logic [23:0] px,
                       output logic ev, output logic [95:0] ed, output logic el);
    int c;
    c = mcol[id];
    hist[id][c] = (nc == 3) ? px : {16'h0, px[7:0]};
    ev = c >= k - 1 && (c - (k - 1)) % s == 0;
    el = ev && (c + s > w - 1);
    ed = '0;
    if (ev) for (int j = 0; j < k; j++) ed = ed | (96'(hist[id][c - k + 1 + j]) << (j * nc * 8));
    mcol[id] = (c + 1) % w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ev, el, acc, hs;
    logic [95:0] ed, bexp, cexp;
    int nwin;
    #2;
    chk("reset_valid", a_v, 0);
    chk("reset_data", a_d, 0);
    chk("reset_last", a_l, 0);
    chk("reset_prev_rdy", a_rdy, 0);
    do_reset();

    tbl[0]  = mk(1, 1, 8'd0,  0, 24'h0,      0, 1);
    tbl[1]  = mk(1, 1, 8'd1,  0, 24'h0,      0, 1);
    tbl[2]  = mk(1, 1, 8'd2,  1, 24'h020100, 0, 1);
    tbl[3]  = mk(1, 1, 8'd3,  1, 24'h030201, 0, 1);
    tbl[4]  = mk(1, 1, 8'd4,  1, 24'h040302, 0, 1);
    tbl[5]  = mk(1, 1, 8'd5,  1, 24'h050403, 0, 1);
    tbl[6]  = mk(1, 1, 8'd6,  1, 24'h060504, 0, 1);
    tbl[7]  = mk(1, 1, 8'd7,  1, 24'h070605, 1, 1);
    tbl[8]  = mk(0, 1, 8'd0,  0, 24'h0,      0, 1);
    tbl[9]  = mk(1, 1, 8'd10, 0, 24'h0,      0, 1);
    tbl[10] = mk(1, 1, 8'd11, 0, 24'h0,      0, 1);
    tbl[11] = mk(1, 1, 8'd12, 1, 24'h0c0b0a, 0, 1);
    tbl[12] = mk(1, 0, 8'd13, 1, 24'h0c0b0a, 0, 0);
    tbl[13] = mk(1, 0, 8'd13, 1, 24'h0c0b0a, 0, 0);
    tbl[14] = mk(1, 0, 8'd13, 1, 24'h0c0b0a, 0, 0);
    tbl[15] = mk(1, 0, 8'd13, 1, 24'h0c0b0a, 0, 0);
    tbl[16] = mk(1, 1, 8'd13, 1, 24'h0d0c0b, 0, 1);
    tbl[17] = mk(0, 1, 8'd0,  0, 24'h0,      0, 1);
    tbl[18] = mk(1, 1, 8'd14, 1, 24'h0e0d0c, 0, 1);
    tbl[19] = mk(1, 1, 8'd15, 1, 24'h0f0e0d, 0, 1);
    tbl[20] = mk(1, 1, 8'd16, 1, 24'h100f0e, 0, 1);
    tbl[21] = mk(1, 1, 8'd17, 1, 24'h11100f, 1, 1);
    tbl[22] = mk(0, 1, 8'd0,  0, 24'h0,      0, 1);
    for (int i = 0; i < 23; i++) begin
      valid = tbl[i].v; rdy = tbl[i].r; din = {16'h0, tbl[i].d};
      #1;
      chk($sformatf("tbl%0d_prev_rdy", i), a_rdy, tbl[i].erdy);
      tick();
      chk($sformatf("tbl%0d_valid", i), a_v, tbl[i].ev);
      chk($sformatf("tbl%0d_last", i), a_l, tbl[i].el);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), a_d, tbl[i].ed);
    end

    // stride-2 and K==W instances share one stream, pixel p carries channels {3p+2,3p+1,3p}
    do_reset();
    rdy = 1'b1;
    for (int p = 0; p < 8; p++) begin
      valid = 1'b1;
      din = {8'(3 * p + 2), 8'(3 * p + 1), 8'(3 * p)};
      tick();
      bexp = {72'h0, 8'(3 * p), 8'(3 * p - 3), 8'(3 * p - 6)};
      chk($sformatf("stride_valid_p%0d", p), b_v, p == 2 || p == 4 || p == 6);
      chk($sformatf("stride_last_p%0d", p), b_l, p == 6);
      if (p == 2 || p == 4 || p == 6) chk($sformatf("stride_data_p%0d", p), b_d, bexp);
      cexp = '0;
      for (int j = 0; j < 12; j++) cexp[j * 8 +: 8] = 8'(3 * (p - 3) + j);
      chk($sformatf("kw_valid_p%0d", p), c_v, p % 4 == 3);
      chk($sformatf("kw_last_p%0d", p), c_l, p % 4 == 3);
      if (p % 4 == 3) chk($sformatf("kw_data_p%0d", p), c_d, cexp);
    end
    valid = 1'b0;
    tick();
    chk("stride_idle", b_v, 0);
    chk("kw_idle", c_v, 0);

    do_reset();
    rdy = 1'b1;
    for (int p = 0; p < 5; p++) begin
      valid = 1'b1; din = 24'(p);
      tick();
    end
    chk("midrow_pending_valid", a_v, 1);
    chk("midrow_pending_data", a_d, 24'h040302);
    valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrow_rst_valid", a_v, 0);
    chk("midrow_rst_last", a_l, 0);
    chk("midrow_rst_prev_rdy", a_rdy, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrow_release_prev_rdy", a_rdy, 1);
    for (int p = 0; p < 3; p++) begin
      valid = 1'b1; din = 24'(20 + p);
      tick();
      chk($sformatf("midrow_after_valid_p%0d", p), a_v, p == 2);
    end
    chk("midrow_first_window", a_d, 24'h161514);

    do_reset();
    rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      valid = $urandom_range(0, 3) != 0;
      din = 24'($urandom);
      #1;
      chk("rnd_prev_rdy", {a_rdy, b_rdy, c_rdy}, 3'b111);
      tick();
      ev = 1'b0; el = 1'b0; ed = '0;
      if (valid) model(0, 3, 1, 8, 1, din, ev, ed, el);
      chk("rnd_a_valid", a_v, ev);
      chk("rnd_a_last", a_l, el);
      if (ev) chk("rnd_a_data", a_d, ed);
      ev = 1'b0; el = 1'b0; ed = '0;
      if (valid) model(1, 3, 2, 8, 1, din, ev, ed, el);
      chk("rnd_b_valid", b_v, ev);
      chk("rnd_b_last", b_l, el);
      if (ev) chk("rnd_b_data", b_d, ed);
      ev = 1'b0; el = 1'b0; ed = '0;
      if (valid) model(2, 4, 1, 4, 3, din, ev, ed, el);
      chk("rnd_c_valid", c_v, ev);
      chk("rnd_c_last", c_l, el);
      if (ev) chk("rnd_c_data", c_d, ed);
    end

    // random back-pressure on the stride-1 instance, windows tracked in a scoreboard
    do_reset();
    nwin = 0;
    exp_q.delete();
    din = 24'($urandom_range(0, 255));
    for (int n = 0; n < 600; n++) begin
      valid = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 2) != 0;
      #1;
      chk("bp_prev_rdy", a_rdy, exp_q.size() == 0 || rdy);
      chk("bp_valid", a_v, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("bp_data", a_d, exp_q[0].d);
        chk("bp_last", a_l, exp_q[0].l);
      end
      acc = valid && a_rdy;
      hs = exp_q.size() != 0 && rdy;
      tick();
      if (hs) begin
        void'(exp_q.pop_front());
        nwin++;
      end
      if (acc) begin
        model(0, 3, 1, 8, 1, din, ev, ed, el);
        if (ev) exp_q.push_back('{ed[23:0], el});
        din = 24'($urandom_range(0, 255));
      end
    end
    valid = 1'b0; rdy = 1'b1;
    tick();
    tick();
    chk("bp_drained", a_v, 0);
    chk("bp_windows_seen", nwin > 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
